// File: rtl/spi_seq_pkg.sv
// Shared constants for the SPI init sequencer: opcodes, FSM state encoding,
// table-entry field positions and the FIFO word packing helper.
package spi_seq_pkg;

  localparam logic [7:0] OP_WRITE = 8'h00;
  localparam logic [7:0] OP_DELAY = 8'h01;
  localparam logic [7:0] OP_END   = 8'hFF;

  localparam logic [3:0] ST_IDLE       = 4'd0;
  localparam logic [3:0] ST_FETCH      = 4'd1;
  localparam logic [3:0] ST_DECODE     = 4'd2;
  localparam logic [3:0] ST_PUSH       = 4'd3;
  localparam logic [3:0] ST_FLUSH      = 4'd4;
  localparam logic [3:0] ST_WAIT_ACK   = 4'd5;
  localparam logic [3:0] ST_WAIT_DRAIN = 4'd6;
  localparam logic [3:0] ST_DELAY      = 4'd7;
  localparam logic [3:0] ST_FIN        = 4'd8;

  localparam int OP_MSB   = 31;
  localparam int OP_LSB   = 24;
  localparam int DATA_MSB = 23;
  localparam int DATA_LSB = 8;
  localparam int ADDR_MSB = 7;
  localparam int ADDR_LSB = 0;

  function automatic logic [31:0] fifo_word(input logic [15:0] data, input logic [7:0] addr);
    return {8'h00, data, addr};
  endfunction

endpackage

// File: rtl/spi_seq_delay.sv
// Loadable 16-bit down-counter with a zero flag, used for DELAY table entries.
module spi_seq_delay (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        dec,
  output logic        zero
);

  logic [15:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= 16'd0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != 16'd0)) begin
      count <= count - 16'd1;
    end
  end

  assign zero = (count == 16'd0);

endmodule

// File: rtl/spi_init_seq.sv
// Table-driven SPI init sequencer: walks a ROM, batches WRITE entries into the
// controller FIFO and kicks bursts. Optional DELAY opcode: SPI_INIT_SEQ_DELAY_EN.
module spi_init_seq
  import spi_seq_pkg::*;
#(
  parameter int TBL_DEPTH = 32,
  parameter int BATCH     = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         go,
  output logic [$clog2(TBL_DEPTH)-1:0] tbl_addr,
  input  logic [31:0]                  tbl_data,
  output logic                         fifo_wren,
  output logic [31:0]                  fifo_data,
  input  logic                         fifo_full,
  input  logic                         fifo_empty,
  output logic                         spi_start,
  input  logic                         spi_busy,
  output logic                         running,
  output logic                         done,
  output logic                         err
);

  localparam int IDX_W = $clog2(TBL_DEPTH);
  localparam int BAT_W = $clog2(BATCH + 1);
  localparam logic [IDX_W:0]   DEPTH_L = (IDX_W + 1)'(TBL_DEPTH);
  localparam logic [BAT_W-1:0] BATCH_L = BAT_W'(BATCH);

  logic [3:0]       state, state_nx;
  logic [IDX_W:0]   idx, idx_nx;
  logic [BAT_W-1:0] batch, batch_nx;
  logic             err_set;
  logic             op_legal;
  logic [7:0]       op;
  logic [15:0]      data_f;
  logic [7:0]       addr_f;

  assign op     = tbl_data[OP_MSB:OP_LSB];
  assign data_f = tbl_data[DATA_MSB:DATA_LSB];
  assign addr_f = tbl_data[ADDR_MSB:ADDR_LSB];

`ifdef SPI_INIT_SEQ_DELAY_EN
  logic dly_load, dly_dec, dly_zero;

  assign op_legal = (op == OP_WRITE) || (op == OP_DELAY) || (op == OP_END);

  spi_seq_delay u_delay (
    .clock    (clock),
    .reset    (reset),
    .load     (dly_load),
    .load_val (data_f),
    .dec      (dly_dec),
    .zero     (dly_zero)
  );
`else
  assign op_legal = (op == OP_WRITE) || (op == OP_END);
`endif

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    batch_nx = batch;
    err_set  = 1'b0;
`ifdef SPI_INIT_SEQ_DELAY_EN
    dly_load = 1'b0;
    dly_dec  = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (go) begin
          idx_nx   = '0;
          batch_nx = '0;
          state_nx = ST_FETCH;
        end
      end
      // running off the end of the table without an END entry is an error
      ST_FETCH: begin
        if (idx >= DEPTH_L) begin
          err_set  = 1'b1;
          state_nx = ST_IDLE;
        end else begin
          state_nx = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (!op_legal) begin
          err_set  = 1'b1;
          state_nx = ST_IDLE;
        end else if (op == OP_WRITE) begin
          state_nx = (fifo_full || (batch == BATCH_L)) ? ST_FLUSH : ST_PUSH;
        end else if (batch != '0) begin
          state_nx = ST_FLUSH;
        end else if (op == OP_END) begin
          state_nx = ST_FIN;
        end
`ifdef SPI_INIT_SEQ_DELAY_EN
        else begin
          dly_load = 1'b1;
          state_nx = ST_DELAY;
        end
`endif
      end
      ST_PUSH: begin
        idx_nx   = idx + 1'b1;
        batch_nx = batch + 1'b1;
        state_nx = ST_FETCH;
      end
      ST_FLUSH:    state_nx = ST_WAIT_ACK;
      ST_WAIT_ACK: if (spi_busy) state_nx = ST_WAIT_DRAIN;
      // ROM still holds the current address, so DECODE re-sees the same entry
      ST_WAIT_DRAIN: begin
        if (!spi_busy && fifo_empty) begin
          batch_nx = '0;
          state_nx = ST_DECODE;
        end
      end
`ifdef SPI_INIT_SEQ_DELAY_EN
      ST_DELAY: begin
        if (dly_zero) begin
          idx_nx   = idx + 1'b1;
          state_nx = ST_FETCH;
        end else begin
          dly_dec = 1'b1;
        end
      end
`endif
      ST_FIN:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // All outputs are registered from the next-state decision
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      idx       <= '0;
      batch     <= '0;
      tbl_addr  <= '0;
      fifo_wren <= 1'b0;
      fifo_data <= 32'd0;
      spi_start <= 1'b0;
      running   <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      batch <= batch_nx;
      if (idx_nx < DEPTH_L) tbl_addr <= idx_nx[IDX_W-1:0];
      fifo_wren <= (state_nx == ST_PUSH);
      if (state_nx == ST_PUSH) fifo_data <= fifo_word(data_f, addr_f);
      spi_start <= (state_nx == ST_FLUSH);
      running   <= (state_nx != ST_IDLE);
      done      <= (state_nx == ST_FIN);
      if ((state == ST_IDLE) && go) err <= 1'b0;
      else if (err_set)             err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_init_seq.sv
// Directed bench for spi_init_seq with a registered ROM and a small SPI controller/FIFO model.
module tb_spi_init_seq;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        go = 1'b0;
  logic [4:0]  tbl_addr;
  logic [31:0] tbl_data;
  logic        fifo_wren;
  logic [31:0] fifo_data;
  logic        fifo_full = 1'b0;
  logic        fifo_empty = 1'b1;
  logic        spi_start;
  logic        spi_busy = 1'b0;
  logic        running, done, err;

  logic        go2 = 1'b0;
  logic [1:0]  tbl_addr2;
  logic [31:0] tbl_data2;
  logic        fifo_wren2;
  logic [31:0] fifo_data2;
  logic        fifo_full2 = 1'b0;
  logic        fifo_empty2 = 1'b1;
  logic        spi_start2;
  logic        spi_busy2 = 1'b0;
  logic        running2, done2, err2;

  int total = 0;
  int bad = 0;

  spi_init_seq #(.TBL_DEPTH(32), .BATCH(8)) dut (
    .clock(clock), .reset(reset), .go(go), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .fifo_wren(fifo_wren), .fifo_data(fifo_data), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .spi_start(spi_start), .spi_busy(spi_busy), .running(running), .done(done), .err(err)
  );

  spi_init_seq #(.TBL_DEPTH(4), .BATCH(8)) dut2 (
    .clock(clock), .reset(reset), .go(go2), .tbl_addr(tbl_addr2), .tbl_data(tbl_data2),
    .fifo_wren(fifo_wren2), .fifo_data(fifo_data2), .fifo_full(fifo_full2), .fifo_empty(fifo_empty2),
    .spi_start(spi_start2), .spi_busy(spi_busy2), .running(running2), .done(done2), .err(err2)
  );

  always #5 clock = ~clock;

  logic [31:0] rom  [0:31];
  logic [31:0] rom2 [0:3];

  always @(posedge clock) begin
    tbl_data  <= rom[tbl_addr];
    tbl_data2 <= rom2[tbl_addr2];
  end

  // Controller model: busy two cycles after start, drains one word per cycle
  int cyc = 0, fcnt = 0, ack_dly = 0;
  bit busy_r = 1'b0, force_full = 1'b0;
  int n_push = 0, n_start = 0, n_done = 0, n_drain = 0, n_wfull = 0;
  int n_push2 = 0, n_start2 = 0, n_done2 = 0;
  logic [31:0] push_log [0:127];
  int push_cyc [0:127];
  int drain_log [0:31];

  always @(negedge clock) begin
    cyc++;
    if (fifo_wren === 1'b1) begin
      if (fifo_full) n_wfull++;
      if (n_push < 128) begin push_log[n_push] = fifo_data; push_cyc[n_push] = cyc; end
      n_push++;
      fcnt++;
    end
    if (busy_r) begin
      if (fcnt > 0) fcnt--;
      else begin
        busy_r = 1'b0;
        if (n_drain < 32) drain_log[n_drain] = cyc;
        n_drain++;
      end
    end
    if (ack_dly > 0) begin ack_dly--; if (ack_dly == 0) busy_r = 1'b1; end
    if (spi_start === 1'b1) begin n_start++; ack_dly = 2; end
    if (done === 1'b1) n_done++;
    if (fifo_wren2 === 1'b1) n_push2++;
    if (spi_start2 === 1'b1) n_start2++;
    if (done2 === 1'b1) n_done2++;
    spi_busy   = busy_r;
    fifo_empty = (fcnt == 0);
    fifo_full  = force_full || (fcnt >= 8);
  end

  function automatic logic [31:0] w_ent(input logic [7:0] a, input logic [15:0] d);
    return {8'h00, d, a};
  endfunction

  function automatic logic [31:0] d_ent(input logic [15:0] n);
    return {8'h01, n, 8'h00};
  endfunction

  localparam logic [31:0] END_ENT = 32'hFF00_0000;

  task automatic clear_rom();
    for (int i = 0; i < 32; i++) rom[i] = END_ENT;
  endtask

  task automatic pulse_go();
    @(negedge clock); go = 1'b1;
    @(negedge clock); go = 1'b0;
  endtask

  task automatic run_to_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (running === 1'b0) begin ok = 1'b1; break; end
    end
    repeat (3) @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    total++; if (tbl_addr !== 5'd0)   begin bad++; $display("FAIL reset_tbl_addr got=%h want=0", tbl_addr); end
    total++; if (fifo_wren !== 1'b0)  begin bad++; $display("FAIL reset_fifo_wren got=%b want=0", fifo_wren); end
    total++; if (fifo_data !== 32'd0) begin bad++; $display("FAIL reset_fifo_data got=%h want=0", fifo_data); end
    total++; if (spi_start !== 1'b0)  begin bad++; $display("FAIL reset_spi_start got=%b want=0", spi_start); end
    total++; if (running !== 1'b0)    begin bad++; $display("FAIL reset_running got=%b want=0", running); end
    total++; if (done !== 1'b0)       begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (err !== 1'b0)        begin bad++; $display("FAIL reset_err got=%b want=0", err); end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_single();
    int pb, sb, db, lat; bit ok;
    clear_rom();
    rom[0] = w_ent(8'h12, 16'hABCD);
    pb = n_push; sb = n_start; db = n_done;
    pulse_go();
    lat = 1;
    while (fifo_wren !== 1'b1 && lat < 10) begin @(negedge clock); lat++; end
    total++; if (lat > 3) begin bad++; $display("FAIL single_latency got=%0d want<=3", lat); end
    run_to_idle(200, ok);
    total++; if (!ok) begin bad++; $display("FAIL single_timeout got=busy want=idle"); end
    total++; if (n_push - pb != 1) begin bad++; $display("FAIL single_pushes got=%0d want=1", n_push - pb); end
    total++; if (push_log[pb] !== 32'h00ABCD12) begin bad++; $display("FAIL single_word got=%h want=00abcd12", push_log[pb]); end
    total++; if (n_start - sb != 1) begin bad++; $display("FAIL single_starts got=%0d want=1", n_start - sb); end
    total++; if (n_done - db != 1) begin bad++; $display("FAIL single_done got=%0d want=1", n_done - db); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL single_err got=%b want=0", err); end
  endtask

  task automatic test_batch();
    int pb, sb, db, drb; bit ok;
    clear_rom();
    for (int i = 0; i < 10; i++) rom[i] = w_ent(8'(i + 1), 16'(16'h1000 + i));
    pb = n_push; sb = n_start; db = n_done; drb = n_drain;
    pulse_go();
    run_to_idle(400, ok);
    total++; if (!ok) begin bad++; $display("FAIL batch_timeout got=busy want=idle"); end
    total++; if (n_push - pb != 10) begin bad++; $display("FAIL batch_pushes got=%0d want=10", n_push - pb); end
    total++; if (n_start - sb != 2) begin bad++; $display("FAIL batch_starts got=%0d want=2", n_start - sb); end
    total++; if (n_done - db != 1) begin bad++; $display("FAIL batch_done got=%0d want=1", n_done - db); end
    total++; if (!(push_cyc[pb + 7] < drain_log[drb] && drain_log[drb] < push_cyc[pb + 8]))
      begin bad++; $display("FAIL batch_split got=p7@%0d drain@%0d p8@%0d want=8 before drain", push_cyc[pb + 7], drain_log[drb], push_cyc[pb + 8]); end
    for (int i = 0; i < 10; i++) begin
      total++;
      if (push_log[pb + i] !== w_ent(8'(i + 1), 16'(16'h1000 + i)))
        begin bad++; $display("FAIL batch_word%0d got=%h want=%h", i, push_log[pb + i], w_ent(8'(i + 1), 16'(16'h1000 + i))); end
    end
  endtask

  task automatic test_delay();
    int pb, sb, db, drb; bit ok;
    clear_rom();
    rom[0] = w_ent(8'h01, 16'h1111);
    rom[1] = d_ent(16'd20);
    rom[2] = w_ent(8'h02, 16'h2222);
    pb = n_push; sb = n_start; db = n_done; drb = n_drain;
    pulse_go();
    run_to_idle(400, ok);
    total++; if (!ok) begin bad++; $display("FAIL delay_timeout got=busy want=idle"); end
`ifdef SPI_INIT_SEQ_DELAY_EN
    total++; if (n_push - pb != 2) begin bad++; $display("FAIL delay_pushes got=%0d want=2", n_push - pb); end
    total++; if (n_start - sb != 2) begin bad++; $display("FAIL delay_starts got=%0d want=2", n_start - sb); end
    total++; if (n_done - db != 1) begin bad++; $display("FAIL delay_done got=%0d want=1", n_done - db); end
    total++; if (push_cyc[pb + 1] - drain_log[drb] < 20)
      begin bad++; $display("FAIL delay_gap got=%0d want>=20", push_cyc[pb + 1] - drain_log[drb]); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL delay_err got=%b want=0", err); end
`else
    total++; if (n_push - pb != 1) begin bad++; $display("FAIL nodelay_pushes got=%0d want=1", n_push - pb); end
    total++; if (n_start - sb != 0) begin bad++; $display("FAIL nodelay_starts got=%0d want=0", n_start - sb); end
    total++; if (n_done - db != 0) begin bad++; $display("FAIL nodelay_done got=%0d want=0", n_done - db); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL nodelay_err got=%b want=1", err); end
`endif
  endtask

  task automatic test_illegal();
    int pb, sb, db; bit ok;
    clear_rom();
    rom[0] = w_ent(8'h10, 16'h0001);
    rom[1] = w_ent(8'h11, 16'h0002);
    rom[2] = 32'h3700_0000;
    pb = n_push; sb = n_start; db = n_done;
    pulse_go();
    run_to_idle(200, ok);
    total++; if (!ok) begin bad++; $display("FAIL illegal_timeout got=busy want=idle"); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL illegal_err got=%b want=1", err); end
    total++; if (n_push - pb != 2) begin bad++; $display("FAIL illegal_pushes got=%0d want=2", n_push - pb); end
    total++; if (n_start - sb != 0) begin bad++; $display("FAIL illegal_starts got=%0d want=0", n_start - sb); end
    total++; if (n_done - db != 0) begin bad++; $display("FAIL illegal_done got=%0d want=0", n_done - db); end
    rom[2] = END_ENT;
    sb = n_start; db = n_done;
    pulse_go();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL illegal_goclr got=%b want=0", err); end
    run_to_idle(200, ok);
    total++; if (n_done - db != 1 || err !== 1'b0) begin bad++; $display("FAIL illegal_rerun got=done%0d err%b want=done1 err0", n_done - db, err); end
  endtask

  task automatic test_full();
    int pb, sb, db, wf; bit ok;
    clear_rom();
    rom[0] = w_ent(8'h20, 16'h00AA);
    force_full = 1'b1;
    pb = n_push; sb = n_start; db = n_done; wf = n_wfull;
    pulse_go();
    repeat (40) @(negedge clock);
    total++; if (n_push - pb != 0) begin bad++; $display("FAIL full_pushes got=%0d want=0", n_push - pb); end
    total++; if (n_start - sb < 1) begin bad++; $display("FAIL full_flush got=%0d want>=1", n_start - sb); end
    force_full = 1'b0;
    run_to_idle(200, ok);
    total++; if (n_push - pb != 1 || n_done - db != 1)
      begin bad++; $display("FAIL full_release got=push%0d done%0d want=push1 done1", n_push - pb, n_done - db); end
    total++; if (n_wfull - wf != 0) begin bad++; $display("FAIL full_wren_while_full got=%0d want=0", n_wfull - wf); end
  endtask

  task automatic test_nodepth();
    bit ok;
    for (int i = 0; i < 4; i++) rom2[i] = w_ent(8'(8'h30 + i), 16'(i));
    @(negedge clock); go2 = 1'b1;
    @(negedge clock); go2 = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (running2 === 1'b0) begin ok = 1'b1; break; end
    end
    total++; if (!ok) begin bad++; $display("FAIL nodepth_timeout got=busy want=idle"); end
    total++; if (err2 !== 1'b1) begin bad++; $display("FAIL nodepth_err got=%b want=1", err2); end
    total++; if (n_push2 != 4) begin bad++; $display("FAIL nodepth_pushes got=%0d want=4", n_push2); end
    total++; if (n_done2 != 0 || n_start2 != 0) begin bad++; $display("FAIL nodepth_done got=done%0d start%0d want=0 0", n_done2, n_start2); end
  endtask

  task automatic test_reset_drain();
    int pb, sb, db, w; bit ok;
    clear_rom();
    for (int i = 0; i < 10; i++) rom[i] = w_ent(8'(8'h40 + i), 16'(16'h5000 + i));
    pulse_go();
    w = 0;
    while (spi_busy !== 1'b1 && w < 200) begin @(negedge clock); w++; end
    total++; if (w >= 200) begin bad++; $display("FAIL rstdrain_busy got=never want=busy"); end
    @(negedge clock);
    reset = 1'b1;
    sb = n_start;
    @(negedge clock);
    total++; if ({tbl_addr, fifo_wren, fifo_data, spi_start, running, done, err} !== '0)
      begin bad++; $display("FAIL rstdrain_outputs got=addr%h wren%b data%h start%b run%b done%b err%b want=all0",
        tbl_addr, fifo_wren, fifo_data, spi_start, running, done, err); end
    reset = 1'b0;
    repeat (30) @(negedge clock);
    total++; if (n_start - sb != 0) begin bad++; $display("FAIL rstdrain_nostart got=%0d want=0", n_start - sb); end
    pb = n_push; db = n_done;
    pulse_go();
    run_to_idle(400, ok);
    total++; if (push_log[pb] !== w_ent(8'h40, 16'h5000)) begin bad++; $display("FAIL rstdrain_restart got=%h want=%h", push_log[pb], w_ent(8'h40, 16'h5000)); end
    total++; if (n_push - pb != 10 || n_done - db != 1)
      begin bad++; $display("FAIL rstdrain_complete got=push%0d done%0d want=push10 done1", n_push - pb, n_done - db); end
  endtask

  initial begin
    clear_rom();
    for (int i = 0; i < 4; i++) rom2[i] = END_ENT;
    test_reset();
    test_single();
    test_batch();
    test_delay();
    test_illegal();
    test_full();
    test_nodepth();
    test_reset_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
